// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the datapath: T0-T2 instruction fetch, opcode decode,
// then per-class micro-steps (two-operand ALU, NEG/NOT, MUL/DIV, NOP, HALT).
module control_sequencer #(
   parameter int unsigned OPW = 5,
   parameter int unsigned RFW = 4
) (
   input  logic            Clock,
   input  logic            Clear,
   input  logic            Run,
   input  logic            Mem_ready,
   input  logic [31:0]     IR,
   output logic            PCout,
   output logic            Zhighout,
   output logic            Zlowout,
   output logic            MDRout,
   output logic            MARin,
   output logic            Zin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            HIin,
   output logic            LOin,
   output logic            IncPC,
   output logic            Read,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic [11:0]     ALU_op,
   output logic            Done,
   output logic            Halted
);

   localparam int unsigned IR_W     = 32;
   localparam int unsigned FIELDS_W = 3 * RFW;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
   localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01001);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_UNARY, C_MULDIV, C_NOP, C_HALT
   } op_class_t;

   state_t           state_q, state_d;
   logic [OPW-1:0]   opcode_q;
   op_class_t        op_class;
   logic [11:0]      alu_onehot;
   logic             unused_ir;

   // Register fields are consumed by the datapath, not here.
   assign unused_ir = ^{IR[IR_W-1-OPW -: FIELDS_W], IR[IR_W-1-OPW-FIELDS_W:0]};

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Opcode is captured as IR is being loaded, so it is stable from T3 onward.
   always_ff @(posedge Clock) begin
      if (!Clear) begin
         opcode_q <= '0;
      end else if (state_q == S_T2) begin
         opcode_q <= IR[IR_W-1 -: OPW];
      end
   end

   // Opcode class and one-hot ALU function; unknown opcodes behave as NOP.
   always_comb begin
      op_class   = C_NOP;
      alu_onehot = '0;
      case (opcode_q)
         OP_ADD:  begin op_class = C_ALU;    alu_onehot[0]  = 1'b1; end
         OP_SUB:  begin op_class = C_ALU;    alu_onehot[1]  = 1'b1; end
         OP_AND:  begin op_class = C_ALU;    alu_onehot[2]  = 1'b1; end
         OP_OR:   begin op_class = C_ALU;    alu_onehot[3]  = 1'b1; end
         OP_SHR:  begin op_class = C_ALU;    alu_onehot[4]  = 1'b1; end
         OP_SHL:  begin op_class = C_ALU;    alu_onehot[5]  = 1'b1; end
         OP_ROR:  begin op_class = C_ALU;    alu_onehot[6]  = 1'b1; end
         OP_ROL:  begin op_class = C_ALU;    alu_onehot[7]  = 1'b1; end
         OP_MUL:  begin op_class = C_MULDIV; alu_onehot[8]  = 1'b1; end
         OP_DIV:  begin op_class = C_MULDIV; alu_onehot[9]  = 1'b1; end
         OP_NEG:  begin op_class = C_UNARY;  alu_onehot[10] = 1'b1; end
         OP_NOT:  begin op_class = C_UNARY;  alu_onehot[11] = 1'b1; end
         OP_HALT: begin op_class = C_HALT; end
         default: begin op_class = C_NOP; end
      endcase
   end

   // Next state and Moore outputs.
   always_comb begin
      state_d  = state_q;
      PCout    = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      Zin      = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      Rin      = 1'b0;
      Rout     = 1'b0;
      ALU_op   = '0;
      Done     = 1'b0;
      Halted   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Run) state_d = S_T0;
         end
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            if (Mem_ready) state_d = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            case (op_class)
               C_ALU: begin
                  Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                  state_d = S_T4;
               end
               C_UNARY: begin
                  Grb = 1'b1; Rout = 1'b1; ALU_op = alu_onehot; Zin = 1'b1;
                  state_d = S_T4;
               end
               C_MULDIV: begin
                  Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                  state_d = S_T4;
               end
               C_HALT: begin
                  state_d = S_HALT;
               end
               default: begin
                  Done    = 1'b1;
                  state_d = Run ? S_T0 : S_IDLE;
               end
            endcase
         end
         S_T4: begin
            case (op_class)
               C_ALU: begin
                  Grc = 1'b1; Rout = 1'b1; ALU_op = alu_onehot; Zin = 1'b1;
                  state_d = S_T5;
               end
               C_UNARY: begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
                  state_d = Run ? S_T0 : S_IDLE;
               end
               C_MULDIV: begin
                  Grb = 1'b1; Rout = 1'b1; ALU_op = alu_onehot; Zin = 1'b1;
                  state_d = S_T5;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_T5: begin
            case (op_class)
               C_ALU: begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
                  state_d = Run ? S_T0 : S_IDLE;
               end
               C_MULDIV: begin
                  Zlowout = 1'b1; LOin = 1'b1;
                  state_d = S_T6;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_T6: begin
            Zhighout = 1'b1; HIin = 1'b1; Done = 1'b1;
            state_d = Run ? S_T0 : S_IDLE;
         end
         S_HALT: begin
            Halted = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction's expected control-word
// sequence is built from the fetch/decode step tables and compared every cycle.
`timescale 1ns/1ps
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Clear, Run, Mem_ready;
   logic [31:0] IR;
   logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
   logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Done, Halted;
   logic [11:0] ALU_op;

   int total = 0;
   int bad   = 0;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
      .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
      .Grc(Grc), .Rin(Rin), .Rout(Rout), .ALU_op(ALU_op), .Done(Done), .Halted(Halted)
   );

   always #5 Clock = ~Clock;

   // Observed control word: ALU_op in [11:0], single-bit lines above it.
   logic [32:0] obs;
   assign obs = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                 HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Done, Halted, ALU_op};

   localparam logic [32:0] M_HALTED   = 33'd1 << 12;
   localparam logic [32:0] M_DONE     = 33'd1 << 13;
   localparam logic [32:0] M_ROUT     = 33'd1 << 14;
   localparam logic [32:0] M_RIN      = 33'd1 << 15;
   localparam logic [32:0] M_GRC      = 33'd1 << 16;
   localparam logic [32:0] M_GRB      = 33'd1 << 17;
   localparam logic [32:0] M_GRA      = 33'd1 << 18;
   localparam logic [32:0] M_READ     = 33'd1 << 19;
   localparam logic [32:0] M_INCPC    = 33'd1 << 20;
   localparam logic [32:0] M_LOIN     = 33'd1 << 21;
   localparam logic [32:0] M_HIIN     = 33'd1 << 22;
   localparam logic [32:0] M_YIN      = 33'd1 << 23;
   localparam logic [32:0] M_IRIN     = 33'd1 << 24;
   localparam logic [32:0] M_MDRIN    = 33'd1 << 25;
   localparam logic [32:0] M_PCIN     = 33'd1 << 26;
   localparam logic [32:0] M_ZIN      = 33'd1 << 27;
   localparam logic [32:0] M_MARIN    = 33'd1 << 28;
   localparam logic [32:0] M_MDROUT   = 33'd1 << 29;
   localparam logic [32:0] M_ZLOWOUT  = 33'd1 << 30;
   localparam logic [32:0] M_ZHIGHOUT = 33'd1 << 31;
   localparam logic [32:0] M_PCOUT    = 33'd1 << 32;

   localparam logic [32:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [32:0] W_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
   localparam logic [32:0] W_T2 = M_MDROUT | M_IRIN;

   // ALU_op bit for an opcode, or -1 for NOP/HALT/illegal.
   function automatic int alu_index(input logic [4:0] op);
      case (op)
         5'b00011: return 0;   5'b00100: return 1;   5'b00101: return 2;
         5'b00110: return 3;   5'b00111: return 4;   5'b01000: return 5;
         5'b01001: return 6;   5'b01010: return 7;   5'b01111: return 8;
         5'b10000: return 9;   5'b10001: return 10;  5'b10010: return 11;
         default:  return -1;
      endcase
   endfunction

   // Number of post-fetch steps: ALU 3, MUL/DIV 4, NEG/NOT 2, NOP/HALT 1.
   function automatic int n_steps(input logic [4:0] op);
      int k;
      k = alu_index(op);
      if (k < 0) return 1;
      if (k <= 7) return 3;
      if (k <= 9) return 4;
      return 2;
   endfunction

   function automatic logic [32:0] exp_word(input logic [4:0] op, input int s);
      int k;
      logic [32:0] alu;
      k = alu_index(op);
      if (k < 0) return (op == 5'b11011) ? 33'd0 : M_DONE;
      alu = 33'd1 << k;
      if (k <= 7) begin
         case (s)
            0: return M_GRB | M_ROUT | M_YIN;
            1: return M_GRC | M_ROUT | M_ZIN | alu;
            default: return M_ZLOWOUT | M_GRA | M_RIN | M_DONE;
         endcase
      end else if (k <= 9) begin
         case (s)
            0: return M_GRA | M_ROUT | M_YIN;
            1: return M_GRB | M_ROUT | M_ZIN | alu;
            2: return M_ZLOWOUT | M_LOIN;
            default: return M_ZHIGHOUT | M_HIIN | M_DONE;
         endcase
      end
      if (s == 0) return M_GRB | M_ROUT | M_ZIN | alu;
      return M_ZLOWOUT | M_GRA | M_RIN | M_DONE;
   endfunction

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Compare the current state's outputs, then advance one clock.
   task automatic step(input string tag, input logic [32:0] exp);
      check(tag, obs, exp);
      @(posedge Clock);
      #1;
   endtask

   // Runs one instruction starting in T0; leaves the DUT in T0 (run_next) or IDLE.
   task automatic do_instr(input string tag, input logic [31:0] ir, input int waits,
                           input bit run_next);
      logic [4:0] op;
      int n;
      op = ir[31:27];
      n  = n_steps(op);
      IR = ir;
      Run = 1'($urandom); Mem_ready = 1'($urandom);
      step({tag, ":T0"}, W_T0);
      for (int i = 0; i <= waits; i++) begin
         Run = 1'($urandom);
         Mem_ready = (i == waits);
         step({tag, ":T1"}, W_T1);
      end
      Run = 1'($urandom); Mem_ready = 1'($urandom);
      step({tag, ":T2"}, W_T2);
      IR = $urandom;
      for (int s = 0; s < n; s++) begin
         Mem_ready = 1'($urandom);
         Run = (s == n - 1) ? run_next : 1'($urandom);
         step({tag, ":exec"}, exp_word(op, s));
      end
   endtask

   task automatic leave_idle(input string tag);
      Run = 1'b1;
      step({tag, ":idle"}, 33'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ir;
      logic [4:0]  op;
      bit          rn;
      Clear = 1'b0; Run = 1'b1; Mem_ready = 1'b0; IR = '0;
      repeat (2) begin
         @(posedge Clock); #1;
         check("reset", obs, 33'd0);
      end
      Clear = 1'b1; Run = 1'b0;
      repeat (3) step("idle_hold", 33'd0);
      leave_idle("start");

      do_instr("neg", 32'h8A900000, 0, 1'b0);
      Run = 1'b0; step("neg_idle", 33'd0);
      leave_idle("add_go");
      do_instr("add", 32'h1A920000, 0, 1'b0);
      leave_idle("mul_go");
      do_instr("mul", 32'h78000000, 3, 1'b0);
      leave_idle("not_go");
      do_instr("not1", 32'h90000000, 1, 1'b1);
      do_instr("not2", 32'h90000000, 0, 1'b0);
      Run = 1'b0; step("not_idle", 33'd0);
      leave_idle("ill_go");
      do_instr("illegal", 32'hF8000000, 0, 1'b1);
      do_instr("div", 32'h80000000, 2, 1'b1);

      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 13))
               0: op = 5'b00011;  1: op = 5'b00100;  2: op = 5'b00101;  3: op = 5'b00110;
               4: op = 5'b00111;  5: op = 5'b01000;  6: op = 5'b01001;  7: op = 5'b01010;
               8: op = 5'b01111;  9: op = 5'b10000;  10: op = 5'b10001; 11: op = 5'b10010;
               default: op = 5'b11010;
            endcase
         end else begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11111;
         end
         ir = {op, 27'($urandom)};
         rn = 1'($urandom);
         do_instr("rand", ir, $urandom_range(0, 3), rn);
         if (!rn) begin
            Run = 1'b0;
            repeat ($urandom_range(0, 2)) step("rand_idle", 33'd0);
            leave_idle("rand_go");
         end
      end

      IR = 32'h18000000; Run = 1'b1; Mem_ready = 1'b0;
      step("clr_t1:T0", W_T0);
      Clear = 1'b0;
      step("clr_t1:T1", W_T1);
      Clear = 1'b1; Run = 1'b0;
      step("clr_t1:idle", 33'd0);
      leave_idle("halt_go");

      do_instr("halt", 32'hD8000000, 1, 1'b1);
      repeat (6) begin
         Run = 1'($urandom); Mem_ready = 1'($urandom);
         step("halted", M_HALTED);
      end
      Clear = 1'b0;
      step("clr_halt:halted", M_HALTED);
      Clear = 1'b1; Run = 1'b0;
      step("clr_halt:idle", 33'd0);
      step("clr_halt:idle2", 33'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
